// File: rtl/vga_layer_compositor_if.sv
// Pixel-source and VGA-pin bundle for vga_layer_compositor.
// The compositor holds the master side; sources/pins hold the slave side.
interface vga_layer_compositor_if #(
   parameter int N_LAYERS = 4,
   parameter int COLOR_W  = 4,
   parameter int ROW_W    = 10,
   parameter int COL_W    = 10
);
   logic [ROW_W-1:0]              row_addr;
   logic [COL_W-1:0]              col_addr;
   logic                          rdn;
   logic [N_LAYERS-1:0]           px_layer;
   logic [N_LAYERS*3*COLOR_W-1:0] layer_color;
   logic [3*COLOR_W-1:0]          bg_color;
   logic [COLOR_W-1:0]            r;
   logic [COLOR_W-1:0]            g;
   logic [COLOR_W-1:0]            b;
   logic                          hs;
   logic                          vs;
   logic                          px;
   logic                          collide;

   modport master (
      output row_addr, col_addr, rdn,
      output r, g, b, hs, vs, px, collide,
      input  px_layer, layer_color, bg_color
   );

   modport slave (
      input  row_addr, col_addr, rdn,
      input  r, g, b, hs, vs, px, collide,
      output px_layer, layer_color, bg_color
   );
endinterface

// File: rtl/vga_layer_compositor.sv
// VGA timing, priority layer compositor and frame-sticky collision flag.
// Optional VGA_FRAME_CNT_EN adds frame_cnt / frame_start outputs.
module vga_layer_compositor #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int N_LAYERS = 4,
   parameter int COLOR_W  = 4,
   parameter int COLL_A   = 1,
   parameter int COLL_B   = 3
) (
   input  logic        vga_clk,
   input  logic        clrn,
`ifdef VGA_FRAME_CNT_EN
   output logic [15:0] frame_cnt,
   output logic        frame_start,
`endif
   vga_layer_compositor_if.master bus
);
   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int COL_W = $clog2(H_TOT);
   localparam int ROW_W = $clog2(V_TOT);
   localparam int PIX_W = 3 * COLOR_W;

   logic [COL_W-1:0] h_q, h_d, col_q, col_d;
   logic [ROW_W-1:0] v_q, v_d, row_q, row_d;
   logic             rdn_q, rdn_d;
   logic             hs1_q, hs1_d, vs1_q, vs1_d, vis1_q, vis1_d;
   logic             hs2_q, hs2_d, vs2_q, vs2_d, vis2_q, vis2_d;
   logic [PIX_W-1:0] rgb_q, rgb_d, sel;
   logic             hs_q, hs_d, vs_q, vs_d, px_q, px_d;
   logic             acc_q, acc_d, coll_q, coll_d;
   logic             h_end, v_end, wrap, hit;
   logic [31:0]      h_w, v_w;

   always_comb begin
      h_w    = 32'(h_q);
      v_w    = 32'(v_q);
      h_end  = (h_w == 32'(H_TOT - 1));
      v_end  = (v_w == 32'(V_TOT - 1));
      wrap   = h_end & v_end;
      h_d    = h_end ? '0 : h_q + COL_W'(1);
      v_d    = v_q;
      if (h_end)
         v_d = v_end ? '0 : v_q + ROW_W'(1);

      col_d  = h_q;
      row_d  = v_q;
      vis1_d = (h_w < 32'(H_ACTIVE)) && (v_w < 32'(V_ACTIVE));
      rdn_d  = ~vis1_d;
      hs1_d  = (h_w >= 32'(H_ACTIVE + H_FP)) &&
               (h_w <  32'(H_ACTIVE + H_FP + H_SYNC));
      vs1_d  = (v_w >= 32'(V_ACTIVE + V_FP)) &&
               (v_w <  32'(V_ACTIVE + V_FP + V_SYNC));

      // Aligns sync/visible with the source's one-register pixel latency
      hs2_d  = hs1_q;
      vs2_d  = vs1_q;
      vis2_d = vis1_q;

      sel = bus.bg_color;
      for (int i = N_LAYERS - 1; i >= 0; i--)
         if (bus.px_layer[i])
            sel = bus.layer_color[i*PIX_W +: PIX_W];

      rgb_d  = vis2_q ? sel : '0;
      px_d   = vis2_q & (|bus.px_layer);
      hs_d   = hs2_q ? SYNC_POL : ~SYNC_POL;
      vs_d   = vs2_q ? SYNC_POL : ~SYNC_POL;

      hit    = vis2_q & bus.px_layer[COLL_A] & bus.px_layer[COLL_B];
      acc_d  = wrap ? 1'b0 : (acc_q | hit);
      coll_d = wrap ? (acc_q | hit) : coll_q;
   end

   always_ff @(posedge vga_clk) begin
      if (!clrn) begin
         h_q    <= '0;
         v_q    <= '0;
         col_q  <= '0;
         row_q  <= '0;
         rdn_q  <= 1'b1;
         hs1_q  <= 1'b0;
         vs1_q  <= 1'b0;
         vis1_q <= 1'b0;
         hs2_q  <= 1'b0;
         vs2_q  <= 1'b0;
         vis2_q <= 1'b0;
         rgb_q  <= '0;
         px_q   <= 1'b0;
         hs_q   <= ~SYNC_POL;
         vs_q   <= ~SYNC_POL;
         acc_q  <= 1'b0;
         coll_q <= 1'b0;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         col_q  <= col_d;
         row_q  <= row_d;
         rdn_q  <= rdn_d;
         hs1_q  <= hs1_d;
         vs1_q  <= vs1_d;
         vis1_q <= vis1_d;
         hs2_q  <= hs2_d;
         vs2_q  <= vs2_d;
         vis2_q <= vis2_d;
         rgb_q  <= rgb_d;
         px_q   <= px_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         acc_q  <= acc_d;
         coll_q <= coll_d;
      end
   end

   assign bus.col_addr = col_q;
   assign bus.row_addr = row_q;
   assign bus.rdn      = rdn_q;
   assign bus.r        = rgb_q[2*COLOR_W +: COLOR_W];
   assign bus.g        = rgb_q[COLOR_W +: COLOR_W];
   assign bus.b        = rgb_q[0 +: COLOR_W];
   assign bus.hs       = hs_q;
   assign bus.vs       = vs_q;
   assign bus.px       = px_q;
   assign bus.collide  = coll_q;

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] fcnt_q, fcnt_d;
   logic        fstart_q, fstart_d;

   always_comb begin
      fcnt_d   = wrap ? fcnt_q + 16'd1 : fcnt_q;
      fstart_d = wrap;
   end

   always_ff @(posedge vga_clk) begin
      if (!clrn) begin
         fcnt_q   <= '0;
         fstart_q <= 1'b0;
      end else begin
         fcnt_q   <= fcnt_d;
         fstart_q <= fstart_d;
      end
   end

   assign frame_cnt   = fcnt_q;
   assign frame_start = fstart_q;
`endif
endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed bench for vga_layer_compositor on a 16x8-clock small frame.
// A one-register pixel source models the game-object generators.
module tb_vga_layer_compositor;
   localparam int N   = 4;
   localparam int CW  = 4;
   localparam int RW  = 3;
   localparam int CLW = 4;

   logic clk  = 1'b0;
   logic clrn = 1'b0;
   always #5 clk = ~clk;

   vga_layer_compositor_if #(
      .N_LAYERS(N), .COLOR_W(CW), .ROW_W(RW), .COL_W(CLW)
   ) bus ();

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt;
   logic        frame_start;
`endif

   vga_layer_compositor #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(1'b0), .N_LAYERS(N), .COLOR_W(CW),
      .COLL_A(1), .COLL_B(3)
   ) dut (
      .vga_clk(clk),
      .clrn(clrn),
`ifdef VGA_FRAME_CNT_EN
      .frame_cnt(frame_cnt),
      .frame_start(frame_start),
`endif
      .bus(bus)
   );

   logic [11:0] bg = 12'hABC;
   logic [3:0]  pat_all = 4'b0000;
   logic [3:0]  pat_hit = 4'b0000;
   logic        hit_en = 1'b0;
   logic [2:0]  hit_r = '0;
   logic [3:0]  hit_c = '0;
   logic [3:0]  px_src = '0;

   assign bus.bg_color    = bg;
   assign bus.layer_color = {12'h333, 12'h222, 12'h111, 12'hF0F};
   assign bus.px_layer    = px_src;

   // Source with exactly one register of latency from address to pixel
   always @(posedge clk)
      px_src <= (hit_en && bus.row_addr == hit_r && bus.col_addr == hit_c)
                ? pat_hit : pat_all;

   int cyc = 0;
   always @(posedge clk) cyc <= clrn ? cyc + 1 : 0;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic [3:0]  pat;
      logic [11:0] bg;
      logic [11:0] rgb;
      logic        px;
   } vec_t;

   vec_t vt[9];

   function automatic bit vis_at(int n);
      if (n < 0) return 1'b0;
      return ((n % 16) < 8) && (((n / 16) % 8) < 4);
   endfunction

   function automatic bit hs_at(int n);
      if (n < 0) return 1'b0;
      return ((n % 16) >= 10) && ((n % 16) < 13);
   endfunction

   function automatic bit vs_at(int n);
      if (n < 0) return 1'b0;
      return (((n / 16) % 8) >= 5) && (((n / 16) % 8) < 7);
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at cyc %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clrn = 1'b0;
      repeat (2) step();
      clrn = 1'b1;
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 2000) begin
         step();
         guard++;
      end
      chk("run_to", cyc, target);
   endtask

   task automatic wait_out(input logic [2:0] r, input logic [3:0] c,
                           output bit ok);
      int n;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         n = cyc - 3;
         if (n >= 0 && (n % 16) == int'(c) && ((n / 16) % 8) == int'(r)) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      bit          ok;
      int          n;
      int          pulses;
      logic [3:0]  ec;
      logic [2:0]  er;
      logic [11:0] ergb;

      vt[0] = '{4'b0000, 12'hABC, 12'hABC, 1'b0};
      vt[1] = '{4'b1010, 12'hABC, 12'h111, 1'b1};
      vt[2] = '{4'b1000, 12'hABC, 12'h333, 1'b1};
      vt[3] = '{4'b0100, 12'h000, 12'h222, 1'b1};
      vt[4] = '{4'b0001, 12'h000, 12'hF0F, 1'b1};
      vt[5] = '{4'b1111, 12'h5A3, 12'hF0F, 1'b1};
      vt[6] = '{4'b0110, 12'h5A3, 12'h111, 1'b1};
      vt[7] = '{4'b1100, 12'h5A3, 12'h222, 1'b1};
      vt[8] = '{4'b0000, 12'h5A3, 12'h5A3, 1'b0};

      // Reset values
      clrn = 1'b0;
      repeat (2) step();
      chk("reset_state",
          {bus.col_addr, bus.row_addr, bus.rdn, bus.hs, bus.vs,
           bus.r, bus.g, bus.b, bus.px, bus.collide},
          {4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 12'd0, 1'b0, 1'b0});
      clrn = 1'b1;

      // Full-frame timing sweep with background only
      for (int k = 1; k <= 136; k++) begin
         step();
         n  = k - 1;
         ec = 4'(n % 16);
         er = 3'((n / 16) % 8);
         chk("addr", {bus.col_addr, bus.row_addr, bus.rdn},
             {ec, er, ~vis_at(n)});
         n    = k - 3;
         ergb = vis_at(n) ? 12'hABC : 12'h000;
         chk("pix_sync",
             {bus.hs, bus.vs, bus.r, bus.g, bus.b, bus.px, bus.collide},
             {~hs_at(n), ~vs_at(n), ergb, 1'b0, 1'b0});
      end

      // Table-driven layer priority vectors
      for (int i = 0; i < 9; i++) begin
         bg      = vt[i].bg;
         pat_all = vt[i].pat;
         repeat (3) step();
         wait_out(3'd1, 4'd3, ok);
         chk("vis_timeout", 32'(ok), 32'd1);
         chk("vis_pixel", {bus.r, bus.g, bus.b, bus.px},
             {vt[i].rgb, vt[i].px});
         wait_out(3'd1, 4'd12, ok);
         chk("blank_timeout", 32'(ok), 32'd1);
         chk("blank_pixel", {bus.r, bus.g, bus.b, bus.px}, 32'd0);
      end
      pat_all = 4'b0000;
      bg      = 12'hABC;

      // Single visible overlap -> collide for exactly the next frame
      hit_r = 3'd2; hit_c = 4'd4; pat_hit = 4'b1010; hit_en = 1'b1;
      do_reset();
      run_to(60);
      hit_en = 1'b0;
      run_to(127);
      chk("coll_pre_wrap", 32'(bus.collide), 32'd0);
      run_to(128);
      chk("coll_set", 32'(bus.collide), 32'd1);
      run_to(255);
      chk("coll_hold", 32'(bus.collide), 32'd1);
      run_to(256);
      chk("coll_clear", 32'(bus.collide), 32'd0);

      // Overlap on the last visible pixel of the frame
      hit_r = 3'd3; hit_c = 4'd7; pat_hit = 4'b1111; hit_en = 1'b1;
      do_reset();
      run_to(60);
      hit_en = 1'b0;
      run_to(128);
      chk("coll_corner", 32'(bus.collide), 32'd1);

      // Overlap only in blanking
      hit_r = 3'd1; hit_c = 4'd9; pat_hit = 4'b1010; hit_en = 1'b1;
      do_reset();
      run_to(128);
      chk("coll_blank", 32'(bus.collide), 32'd0);
      hit_en = 1'b0;

      // Layers outside the collision pair
      hit_r = 3'd2; hit_c = 4'd4; pat_hit = 4'b0101; hit_en = 1'b1;
      do_reset();
      run_to(128);
      chk("coll_other", 32'(bus.collide), 32'd0);
      hit_en = 1'b0;

      // Mid-frame reset discards the partial frame's hit
      hit_r = 3'd1; hit_c = 4'd2; pat_hit = 4'b1010; hit_en = 1'b1;
      do_reset();
      run_to(38);
      chk("pre_rst_addr", {bus.col_addr, bus.row_addr}, {4'd5, 3'd2});
      clrn = 1'b0;
      step();
      chk("rst_mid",
          {bus.col_addr, bus.row_addr, bus.rdn, bus.hs, bus.vs,
           bus.r, bus.g, bus.b, bus.px, bus.collide},
          {4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 12'd0, 1'b0, 1'b0});
      clrn   = 1'b1;
      hit_en = 1'b0;
      step();
      chk("rst_release", {bus.col_addr, bus.row_addr, bus.rdn}, 32'd0);
      run_to(128);
      chk("rst_no_coll", 32'(bus.collide), 32'd0);

`ifdef VGA_FRAME_CNT_EN
      do_reset();
      chk("fcnt_reset", 32'(frame_cnt), 32'd0);
      pulses = 0;
      for (int i = 0; i < 2000 && cyc < 384; i++) begin
         step();
         if (frame_start) begin
            pulses++;
            chk("fs_align", 32'(cyc % 128), 32'd0);
         end
      end
      chk("fcnt_3", 32'(frame_cnt), 32'd3);
      chk("fs_pulses", 32'(pulses), 32'd3);
`else
      pulses = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
